// File: rtl/synaptic_acc_engine_pkg.sv
// Shared FSM state type, spike word width and frame sizing helpers
// for the synaptic accumulation engine.
package synaptic_acc_engine_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    function automatic int calc_nw(input int depth);
        return depth / WORD_W;
    endfunction

    function automatic int calc_aw(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/spike_idx_scan.sv
// Holds the current spike word and reports its lowest set bit; each consume
// clears that bit, and a load (which wins over consume) replaces the word.
module spike_idx_scan
    import synaptic_acc_engine_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_word,
    input  logic              i_consume,
    output logic [4:0]        o_idx,
    output logic              o_idx_valid,
    output logic              o_last_bit
);

    logic [WORD_W-1:0] r_word;
    logic [WORD_W-1:0] w_rest;

    assign w_rest = r_word & (r_word - WORD_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word <= '0;
        end else if (i_load) begin
            r_word <= i_word;
        end else if (i_consume) begin
            r_word <= w_rest;
        end
    end

    // Scanning downward leaves the lowest set bit as the final assignment.
    always_comb begin
        o_idx = '0;
        for (int b = WORD_W - 1; b >= 0; b--) begin
            if (r_word[b]) begin
                o_idx = 5'(b);
            end
        end
    end

    assign o_idx_valid = |r_word;
    assign o_last_bit  = ~|w_rest;

endmodule

// File: rtl/synaptic_acc_engine.sv
// Sparse spike-driven synaptic accumulator: each set axon bit reads one weight
// row and adds it into P lane sums. Define SYN_SAT_EN for saturating lane adds.
module synaptic_acc_engine
    import synaptic_acc_engine_pkg::*;
#(
    parameter int P      = 64,
    parameter int SYNWID = 8,
    parameter int MWID   = 16,
    parameter int DEPTH  = 512
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ipt_valid,
    output logic                        ipt_ready,
    input  logic [WORD_W-1:0]           sparse_bits,
    input  logic                        wr_en,
    output logic                        wr_ready,
    input  logic [calc_aw(DEPTH)-1:0]   wr_addr,
    input  logic [P*SYNWID-1:0]         wr_data,
    output logic                        opt_valid,
    input  logic                        opt_ready,
    output logic [P*MWID-1:0]           opt_acc
);

    localparam int NW = calc_nw(DEPTH);
    localparam int AW = calc_aw(DEPTH);
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CW-1:0] LAST_W = CW'(NW - 1);

    state_t                 r_state, w_state_nxt;
    logic [CW-1:0]          r_cnt, r_cur;
    logic                   w_capture, w_issue, w_clear;
    logic [4:0]             w_idx;
    logic                   w_idx_valid, w_last_bit;
    logic [AW-1:0]          w_rd_addr;
    logic [P*SYNWID-1:0]    r_mem [DEPTH];
    logic [P*SYNWID-1:0]    r_rd_row_p1;
    logic                   r_rd_vld_p1;
    logic signed [MWID-1:0] r_acc_p2 [P];

    function automatic logic signed [MWID-1:0] lane_add(
        input logic signed [MWID-1:0]   a,
        input logic signed [SYNWID-1:0] w
    );
        logic [MWID:0] s;
        s = {a[MWID-1], a} + {{(MWID + 1 - SYNWID){w[SYNWID-1]}}, w};
`ifdef SYN_SAT_EN
        if (s[MWID] != s[MWID-1]) begin
            return s[MWID] ? {1'b1, {(MWID-1){1'b0}}} : {1'b0, {(MWID-1){1'b1}}};
        end
`endif
        return s[MWID-1:0];
    endfunction

    spike_idx_scan u_scan (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_capture),
        .i_word      (sparse_bits),
        .i_consume   (w_issue),
        .o_idx       (w_idx),
        .o_idx_valid (w_idx_valid),
        .o_last_bit  (w_last_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ipt_ready   = 1'b0;
        wr_ready    = 1'b0;
        opt_valid   = 1'b0;
        w_capture   = 1'b0;
        w_issue     = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            IDLE: begin
                ipt_ready = 1'b1;
                wr_ready  = (r_cnt == '0);
                if (ipt_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = SCAN;
                end
            end
            SCAN: begin
                w_issue = w_idx_valid;
                if (w_last_bit) begin
                    if (r_cur == LAST_W) begin
                        w_state_nxt = DRAIN;
                    end else begin
                        // Next word can be handed over in the same cycle.
                        ipt_ready = 1'b1;
                        if (ipt_valid) begin
                            w_capture = 1'b1;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end
                end
            end
            DRAIN: w_state_nxt = OUT;
            OUT: begin
                opt_valid = 1'b1;
                if (opt_ready) begin
                    w_clear     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_cnt <= '0;
            r_cur <= '0;
        end else if (w_capture) begin
            r_cur <= r_cnt;
            r_cnt <= (r_cnt == LAST_W) ? '0 : r_cnt + CW'(1);
        end
    end

    assign w_rd_addr = AW'({r_cur, w_idx});

    // Stage p1: weight RAM write port and registered row read.
    always_ff @(posedge clk) begin
        if (wr_en && wr_ready) begin
            r_mem[wr_addr] <= wr_data;
        end
        r_rd_row_p1 <= r_mem[w_rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_vld_p1 <= 1'b0;
        end else begin
            r_rd_vld_p1 <= w_issue;
        end
    end

    // Stage p2: per-lane sign-extended accumulate.
    always_ff @(posedge clk) begin
        for (int i = 0; i < P; i++) begin
            if (rst || w_clear) begin
                r_acc_p2[i] <= '0;
            end else if (r_rd_vld_p1) begin
                r_acc_p2[i] <= lane_add(r_acc_p2[i], r_rd_row_p1[i*SYNWID +: SYNWID]);
            end
        end
    end

    for (genvar g = 0; g < P; g++) begin : g_out
        assign opt_acc[g*MWID +: MWID] = r_acc_p2[g];
    end

endmodule
